// File: rtl/mux_pkg.sv
// Shared constants and helpers for the pipelined N-way selector and its encoder.
package mux_pkg;
    localparam int MODE_BINARY   = 0;
    localparam int MODE_PRIORITY = 1;

    // Select width: clog2 of the input count, never narrower than one bit.
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/priority_index_encoder.sv
// Combinational lowest-index-wins encoder. Returns index 0 and any=0 when no request is set.
module priority_index_encoder
    import mux_pkg::*;
#(
    parameter int N     = 4,
    parameter int SEL_W = sel_width(N)
) (
    input  logic [N-1:0]     req,
    output logic [SEL_W-1:0] idx,
    output logic             any
);
    always_comb begin
        idx = '0;
        any = |req;
        // Walk from the top down so the lowest set bit is the final assignment.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) idx = SEL_W'(i);
        end
    end
endmodule

// File: rtl/pipelined_nway_mux.sv
// Registered N-to-1 selector: binary or priority select, one-cycle latency, stall hold and flush.
module pipelined_nway_mux
    import mux_pkg::*;
#(
    parameter int BITS   = 32,
    parameter int INPUTS = 4,
    parameter int MODE   = MODE_BINARY,
    parameter int SEL_W  = sel_width(INPUTS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   stall,
    input  logic                   flush,
    input  logic                   in_valid,
    input  logic [SEL_W-1:0]       select,
    input  logic [INPUTS-1:0]      req,
    input  logic [INPUTS*BITS-1:0] in_data,
    output logic [BITS-1:0]        out,
    output logic                   out_valid,
    output logic [SEL_W-1:0]       out_sel,
    output logic                   hit
);
    logic [SEL_W-1:0] sel_idx;
    logic             sel_hit;
    logic [BITS-1:0]  sel_data;
    logic [BITS-1:0]  term [INPUTS];

    generate
        if (MODE == MODE_PRIORITY) begin : g_prio
            logic unused_select;
            assign unused_select = ^select;
            priority_index_encoder #(.N(INPUTS), .SEL_W(SEL_W)) u_enc (
                .req (req),
                .idx (sel_idx),
                .any (sel_hit)
            );
        end else begin : g_bin
            logic unused_req;
            assign unused_req = ^req;
            // Out-of-range selects fall back to input 0 and report a miss.
            assign sel_hit = int'(select) < INPUTS;
            assign sel_idx = sel_hit ? select : '0;
        end
    endgenerate

    for (genvar i = 0; i < INPUTS; i++) begin : g_term
        assign term[i] = in_data[i*BITS +: BITS] & {BITS{sel_idx == SEL_W'(i)}};
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < INPUTS; i++) sel_data = sel_data | term[i];
    end

    logic [BITS-1:0]  out_q,   out_d;
    logic             vld_q,   vld_d;
    logic [SEL_W-1:0] sel_q,   sel_d;
    logic             hit_q,   hit_d;

    always_comb begin
        out_d = out_q;
        vld_d = vld_q;
        sel_d = sel_q;
        hit_d = hit_q;
        if (flush) begin
            out_d = '0;
            vld_d = 1'b0;
            sel_d = '0;
            hit_d = 1'b0;
        end else if (!stall) begin
            out_d = sel_data;
            vld_d = in_valid;
            sel_d = sel_idx;
            hit_d = sel_hit;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
            vld_q <= 1'b0;
            sel_q <= '0;
            hit_q <= 1'b0;
        end else begin
            out_q <= out_d;
            vld_q <= vld_d;
            sel_q <= sel_d;
            hit_q <= hit_d;
        end
    end

    assign out       = out_q;
    assign out_valid = vld_q;
    assign out_sel   = sel_q;
    assign hit       = hit_q;
endmodule

// File: tb/tb_pipelined_nway_mux.sv
// Directed bench: binary 4-in, binary 3-in and priority 4-in selectors sharing control.
module tb_pipelined_nway_mux;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic stall = 1'b0, flush = 1'b0, in_valid = 1'b0;

    logic [1:0]   sel_a, sel_b;
    logic [3:0]   req_a, req_b, req_c;
    logic [127:0] data_a, data_c;
    logic [95:0]  data_b;
    logic [1:0]   unused_sel_c;

    logic [31:0] out_a, out_b, out_c;
    logic        vld_a, vld_b, vld_c, hit_a, hit_b, hit_c;
    logic [1:0]  osel_a, osel_b, osel_c;

    int total = 0, bad = 0;

    always #5 clk = ~clk;

    pipelined_nway_mux #(.BITS(32), .INPUTS(4), .MODE(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .in_valid(in_valid),
        .select(sel_a), .req(req_a), .in_data(data_a),
        .out(out_a), .out_valid(vld_a), .out_sel(osel_a), .hit(hit_a));

    pipelined_nway_mux #(.BITS(32), .INPUTS(3), .MODE(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .in_valid(in_valid),
        .select(sel_b), .req(req_b[2:0]), .in_data(data_b),
        .out(out_b), .out_valid(vld_b), .out_sel(osel_b), .hit(hit_b));

    pipelined_nway_mux #(.BITS(32), .INPUTS(4), .MODE(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .in_valid(in_valid),
        .select(unused_sel_c), .req(req_c), .in_data(data_c),
        .out(out_c), .out_valid(vld_c), .out_sel(osel_c), .hit(hit_c));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic [31:0] o, input logic v,
                         input logic [1:0] s, input logic h);
        chk({tag, ".a.out"}, out_a, o);
        chk({tag, ".a.vld"}, 32'(vld_a), 32'(v));
        chk({tag, ".a.sel"}, 32'(osel_a), 32'(s));
        chk({tag, ".a.hit"}, 32'(hit_a), 32'(h));
    endtask

    // Expected tables for the sweep: binary 3-in and priority 4-in.
    logic [31:0] exp_b_out [4] = '{32'h22222222, 32'h33333333, 32'h44444444, 32'h22222222};
    logic [1:0]  exp_b_sel [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
    logic        exp_b_hit [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [3:0]  req_tab   [4] = '{4'b1010, 4'b0000, 4'b1000, 4'b0111};
    logic [31:0] exp_c_out [4] = '{32'hBBBB0001, 32'hAAAA0000, 32'hDDDD0003, 32'hAAAA0000};
    logic [1:0]  exp_c_sel [4] = '{2'd1, 2'd0, 2'd3, 2'd0};
    logic        exp_c_hit [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [31:0] exp_a_out [4] = '{32'hAAAA0000, 32'hBBBB0001, 32'hCCCC0002, 32'hDDDD0003};

    initial begin
        unused_sel_c = 2'd0;
        req_a = 4'd0;
        req_b = 4'd0;
        // Reset held while inputs wiggle and the clock runs.
        for (int i = 0; i < 4; i++) begin
            sel_a = 2'($urandom); sel_b = 2'($urandom); req_c = 4'($urandom);
            in_valid = 1'($urandom);
            data_a = {$urandom, $urandom, $urandom, $urandom};
            data_b = {$urandom, $urandom, $urandom};
            data_c = data_a;
            @(negedge clk);
        end
        chk_a("rst", 32'h0, 1'b0, 2'd0, 1'b0);
        chk("rst.b.vld", 32'(vld_b), 32'h0);
        chk("rst.c.out", out_c, 32'h0);
        chk("rst.c.hit", 32'(hit_c), 32'h0);

        data_a = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
        data_c = data_a;
        data_b = {32'h44444444, 32'h33333333, 32'h22222222};
        in_valid = 1'b1;
        rst_n = 1'b1;

        for (int s = 0; s < 4; s++) begin
            sel_a = 2'(s); sel_b = 2'(s); req_c = req_tab[s];
            @(negedge clk);
            chk_a($sformatf("sweep%0d", s), exp_a_out[s], 1'b1, 2'(s), 1'b1);
            chk($sformatf("sweep%0d.b.out", s), out_b, exp_b_out[s]);
            chk($sformatf("sweep%0d.b.sel", s), 32'(osel_b), 32'(exp_b_sel[s]));
            chk($sformatf("sweep%0d.b.hit", s), 32'(hit_b), 32'(exp_b_hit[s]));
            chk($sformatf("sweep%0d.c.out", s), out_c, exp_c_out[s]);
            chk($sformatf("sweep%0d.c.sel", s), 32'(osel_c), 32'(exp_c_sel[s]));
            chk($sformatf("sweep%0d.c.hit", s), 32'(hit_c), 32'(exp_c_hit[s]));
        end

        // Invalid operation still captures data deterministically.
        in_valid = 1'b0; sel_a = 2'd2;
        @(negedge clk);
        chk_a("novld", 32'hCCCC0002, 1'b0, 2'd2, 1'b1);

        // Capture a marker, then stall with changing inputs.
        data_a[31:0] = 32'h12345678; sel_a = 2'd0; in_valid = 1'b1;
        @(negedge clk);
        chk_a("cap", 32'h12345678, 1'b1, 2'd0, 1'b1);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sel_a = 2'(i + 1); in_valid = 1'b0; data_a[31:0] = $urandom;
            @(negedge clk);
            chk_a($sformatf("stall%0d", i), 32'h12345678, 1'b1, 2'd0, 1'b1);
        end
        flush = 1'b1;
        @(negedge clk);
        chk_a("flush", 32'h0, 1'b0, 2'd0, 1'b0);
        chk("flush.c.out", out_c, 32'h0);
        chk("flush.c.vld", 32'(vld_c), 32'h0);

        // Async reset between edges while valid.
        stall = 1'b0; flush = 1'b0; in_valid = 1'b1; sel_a = 2'd1;
        data_a[31:0] = 32'hAAAA0000;
        @(negedge clk);
        chk_a("pre_arst", 32'hBBBB0001, 1'b1, 2'd1, 1'b1);
        #2 rst_n = 1'b0;
        #1 chk_a("arst", 32'h0, 1'b0, 2'd0, 1'b0);
        @(negedge clk);
        chk_a("arst_hold", 32'h0, 1'b0, 2'd0, 1'b0);
        rst_n = 1'b1; sel_a = 2'd3;
        @(negedge clk);
        chk_a("resume", 32'hDDDD0003, 1'b1, 2'd3, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
